// File: rtl/game_pkg.sv
// Shared types for the dice game: game state and Choose result encodings.
// Imported by game_sequencer, Choose and the display demux.
package game_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'b00,
        ST_ROLL   = 2'b01,
        ST_CHOOSE = 2'b10,
        ST_END    = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        RES_CONTINUE = 2'b00,
        RES_LOST     = 2'b01,
        RES_WON      = 2'b10
    } choose_result_e;

    // Index width for a player count, never below one bit.
    function automatic int player_width(input int num_players);
        return (num_players > 1) ? $clog2(num_players) : 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for level button/handshake lines; the first clock after
// reset only primes the edge register so a line already high gives no event.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;
    logic armed_q;
    logic armed_d;

    // Next values: sample the line every cycle, arm after the first clock.
    always_comb begin
        prev_d  = d;
        armed_d = 1'b1;
    end

    // Edge register and arming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rise = armed_q & d & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Turn/round sequencer for the dice game (START -> ROLL -> CHOOSE -> END).
// Optional macro TURN_LIMIT_EN ends the game after MAX_ROUNDS full rounds.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TURN_W      = 4,
    parameter int MAX_ROUNDS  = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pulse_i,
    input  logic                                   restart_i,
    input  logic [1:0]                             choose_result,
    output logic                                   pulse_o,
    output logic [1:0]                             state,
    output logic [player_width(NUM_PLAYERS)-1:0]   player,
    output logic [TURN_W-1:0]                      turns,
    output logic                                   won,
    output logic [player_width(NUM_PLAYERS)-1:0]   winner
);

    localparam int PW = player_width(NUM_PLAYERS);
    localparam logic [PW-1:0]     LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [TURN_W-1:0] TURN_SAT    = {TURN_W{1'b1}};
    localparam logic [TURN_W-1:0] ROUND_LIMIT = TURN_W'(MAX_ROUNDS);
`ifdef TURN_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    game_state_e       state_q, state_d;
    logic [PW-1:0]     player_q, player_d;
    logic [TURN_W-1:0] turns_q, turns_d;
    logic              won_q, won_d;
    logic [PW-1:0]     winner_q, winner_d;
    logic              pulse_o_q, pulse_o_d;
    logic              rise_s;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (pulse_i),
        .rise (rise_s)
    );

    // Next-state and next-output logic; restart outranks a same-cycle event.
    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        turns_d   = turns_q;
        won_d     = won_q;
        winner_d  = winner_q;
        pulse_o_d = 1'b1;
        if (restart_i) begin
            state_d  = ST_START;
            player_d = '0;
            turns_d  = '0;
            won_d    = 1'b0;
            winner_d = '0;
        end else if (rise_s) begin
            case (state_q)
                ST_START: begin
                    state_d  = ST_ROLL;
                    turns_d  = TURN_W'(1);
                    player_d = '0;
                end
                ST_ROLL: begin
                    state_d   = ST_CHOOSE;
                    pulse_o_d = 1'b0;
                end
                ST_CHOOSE: begin
                    case (choose_result)
                        RES_CONTINUE: begin
                            if (player_q != LAST_PLAYER) begin
                                state_d  = ST_ROLL;
                                player_d = player_q + PW'(1);
                            end else if (LIMIT_EN && (turns_q == ROUND_LIMIT)) begin
                                // Round limit reached on the wrap: nobody won.
                                state_d  = ST_END;
                                won_d    = 1'b0;
                                winner_d = player_q;
                            end else begin
                                state_d  = ST_ROLL;
                                player_d = '0;
                                if (turns_q != TURN_SAT) begin
                                    turns_d = turns_q + TURN_W'(1);
                                end else begin
                                    turns_d = turns_q;
                                end
                            end
                        end
                        RES_LOST: begin
                            state_d  = ST_END;
                            won_d    = 1'b0;
                            winner_d = player_q;
                        end
                        RES_WON: begin
                            state_d  = ST_END;
                            won_d    = 1'b1;
                            winner_d = player_q;
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Game state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_START;
            player_q  <= '0;
            turns_q   <= '0;
            won_q     <= 1'b0;
            winner_q  <= '0;
            pulse_o_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            turns_q   <= turns_d;
            won_q     <= won_d;
            winner_q  <= winner_d;
            pulse_o_q <= pulse_o_d;
        end
    end

    assign state   = state_q;
    assign player  = player_q;
    assign turns   = turns_q;
    assign won     = won_q;
    assign winner  = winner_q;
    assign pulse_o = pulse_o_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (NUM_PLAYERS=2, TURN_W=4, MAX_ROUNDS=3).
// Honours TURN_LIMIT_EN in its reference model when the macro is defined.
module tb_game_sequencer;

    localparam int N      = 2;
    localparam int TW     = 4;
    localparam int MAXR   = 3;
    localparam int TSAT   = (1 << TW) - 1;
`ifdef TURN_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse_i;
    logic       restart_i;
    logic [1:0] choose_result;
    logic       pulse_o;
    logic [1:0] state;
    logic [0:0] player;
    logic [TW-1:0] turns;
    logic       won;
    logic [0:0] winner;

    game_sequencer #(.NUM_PLAYERS(N), .TURN_W(TW), .MAX_ROUNDS(MAXR)) dut (
        .clk           (clk),
        .rst           (rst),
        .pulse_i       (pulse_i),
        .restart_i     (restart_i),
        .choose_result (choose_result),
        .pulse_o       (pulse_o),
        .state         (state),
        .player        (player),
        .turns         (turns),
        .won           (won),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int pl;
        int tu;
        int wo;
        int wi;
        int po;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: phase 0=START 1=ROLL 2=CHOOSE 3=END.
    int m_phase, m_player, m_turns, m_won, m_winner;
    bit m_prev, m_fresh;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_player = 0; m_turns = 0; m_won = 0; m_winner = 0;
        m_prev = 1'b0; m_fresh = 1'b1;
    endtask

    task automatic model_edge(input bit p, input bit r, input int cr);
        bit ev;
        exp_t e;
        int po;
        ev = !m_fresh && p && !m_prev;
        m_prev = p;
        m_fresh = 1'b0;
        po = 1;
        if (r) begin
            m_phase = 0; m_player = 0; m_turns = 0; m_won = 0; m_winner = 0;
        end else if (ev) begin
            if (m_phase == 0) begin
                m_phase = 1; m_turns = 1; m_player = 0;
            end else if (m_phase == 1) begin
                m_phase = 2; po = 0;
            end else if (m_phase == 2) begin
                if (cr == 0) begin
                    if ((m_player + 1) % N != 0) begin
                        m_player = m_player + 1; m_phase = 1;
                    end else if (LIMIT && m_turns == MAXR) begin
                        m_phase = 3; m_won = 0; m_winner = m_player;
                    end else begin
                        m_player = 0; m_phase = 1;
                        m_turns = (m_turns < TSAT) ? m_turns + 1 : TSAT;
                    end
                end else if (cr == 1 || cr == 2) begin
                    m_phase = 3; m_won = (cr == 2) ? 1 : 0; m_winner = m_player;
                end
            end
        end
        e.st = m_phase; e.pl = m_player; e.tu = m_turns;
        e.wo = m_won; e.wi = m_winner; e.po = po;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit p, input bit r, input int cr);
        @(negedge clk);
        rst = 1'b0;
        pulse_i = p;
        restart_i = r;
        choose_result = cr[1:0];
        model_edge(p, r, cr);
    endtask

    // One event: drop the line for a cycle, then raise it with the given code.
    task automatic event_pulse(input int cr);
        step(1'b0, 1'b0, cr);
        step(1'b1, 1'b0, cr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"},   int'(state),   0);
        chk({tag, "_player"},  int'(player),  0);
        chk({tag, "_turns"},   int'(turns),   0);
        chk({tag, "_won"},     int'(won),     0);
        chk({tag, "_winner"},  int'(winner),  0);
        chk({tag, "_pulse_o"}, int'(pulse_o), 1);
    endtask

    // Monitor: one expected entry per clock edge after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("state",   int'(state),   e.st);
                chk("player",  int'(player),  e.pl);
                chk("turns",   int'(turns),   e.tu);
                chk("won",     int'(won),     e.wo);
                chk("winner",  int'(winner),  e.wi);
                chk("pulse_o", int'(pulse_o), e.po);
            end
        end
    end

    initial begin
        rst = 1'b1;
        pulse_i = 1'b1;
        restart_i = 1'b0;
        choose_result = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");

        // Line already high at reset release, then held: no event.
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        repeat (5) step(1'b1, 1'b0, 0);

        // Two full rounds of CONTINUE, then player 1 wins.
        repeat (4) begin
            event_pulse(0);
            event_pulse(0);
        end
        event_pulse(0);
        event_pulse(0);
        event_pulse(0);
        event_pulse(2);
        repeat (3) event_pulse(0);
        event_pulse(1);

        // Restart, then restart racing an event in ROLL.
        step(1'b0, 1'b1, 0);
        event_pulse(0);
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 0);

        // Reserved code in CHOOSE is ignored.
        event_pulse(0);
        event_pulse(0);
        event_pulse(3);
        event_pulse(3);
        step(1'b0, 1'b0, 3);

        // Asynchronous reset between edges while in CHOOSE.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);

        // Long CONTINUE run: round limit or turns saturation.
        event_pulse(0);
        repeat (20 * N) begin
            event_pulse(0);
            event_pulse(0);
        end

        // Randomized play.
        step(1'b0, 1'b1, 0);
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
